dsp_frame_ctrl: RTL and testbench

//  Sequences the RGB 3x3 conv datapath (dsp) over a raster frame. Accepts one packed ARGB32 pixel per

---
 rtl/dsp_frame_ctrl.sv | 157 +++++++++++++++
 tb/tb_dsp_frame_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_frame_ctrl.sv
// ============================================================================
// dsp_frame_ctrl: raster line-buffer sequencer feeding the 3x3 conv datapath.
// Revision 1.0
// ============================================================================
`default_nettype none

module dsp_frame_ctrl #(
  parameter int IMG_W    = 640,
  parameter int IMG_H    = 480,
  parameter int CONV_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  mode_in,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_pix,
  output logic [31:0] dsp_top_pix,
  output logic [31:0] dsp_mid_pix,
  output logic [31:0] dsp_bot_pix,
  output logic        dsp_shift_en,
  output logic [1:0]  dsp_mode,
  input  logic [31:0] dsp_pixel_in,
  output logic        out_valid,
  output logic [31:0] out_pix,
  output logic        out_last,
  output logic        busy,
  output logic        done
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam int CNT_W = $clog2(CONV_LAT + 2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [CNT_W-1:0]  drain_q;
  logic [1:0]        mode_q;
  logic [31:0]       top_q, mid_q, bot_q, out_pix_q;
  logic              shift_en_q, out_valid_q, out_last_q, done_q;
  logic [CONV_LAT:0] qual_q, last_q;

  // lb0 holds row r-1, lb1 holds row r-2; no reset, priming rows hide stale data
  logic [31:0] lb0 [IMG_W];
  logic [31:0] lb1 [IMG_W];

  logic accept, col_end, row_end, frame_end, qual, drain_end;

  assign accept    = in_valid & (state_q == RUN);
  assign col_end   = (col_q == COL_W'(IMG_W - 1));
  assign row_end   = (row_q == ROW_W'(IMG_H - 1));
  assign frame_end = accept & col_end & row_end;
  assign qual      = accept & (row_q >= ROW_W'(2)) & (col_q >= COL_W'(2));
  assign drain_end = (state_q == DRAIN) && (drain_q == CNT_W'(CONV_LAT + 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (frame_end) state_d = DRAIN;
      DRAIN:   if (drain_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (state_q == IDLE && start) begin
      col_d = '0;
      row_d = '0;
    end else if (accept) begin
      if (col_end) begin
        col_d = '0;
        row_d = row_end ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q       <= '0;
      row_q       <= '0;
      drain_q     <= '0;
      mode_q      <= '0;
      top_q       <= '0;
      mid_q       <= '0;
      bot_q       <= '0;
      shift_en_q  <= 1'b0;
      qual_q      <= '0;
      last_q      <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_pix_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      drain_q <= (state_q == DRAIN) ? drain_q + 1'b1 : '0;
      done_q  <= drain_end;
      if (state_q == IDLE && start) mode_q <= mode_in;
      shift_en_q <= accept;
      if (accept) begin
        top_q <= lb1[col_q];
        mid_q <= lb0[col_q];
        bot_q <= in_pix;
      end
      // Qualifier/last markers ride alongside the dsp latency
      qual_q[0] <= qual;
      last_q[0] <= frame_end;
      for (int i = 1; i <= CONV_LAT; i++) begin
        qual_q[i] <= qual_q[i-1];
        last_q[i] <= last_q[i-1];
      end
      out_valid_q <= qual_q[CONV_LAT];
      out_last_q  <= qual_q[CONV_LAT] & last_q[CONV_LAT];
      if (qual_q[CONV_LAT]) out_pix_q <= dsp_pixel_in;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      lb1[col_q] <= lb0[col_q];
      lb0[col_q] <= in_pix;
    end
  end

  assign in_ready     = (state_q == RUN);
  assign busy         = (state_q != IDLE);
  assign done         = done_q;
  assign dsp_top_pix  = top_q;
  assign dsp_mid_pix  = mid_q;
  assign dsp_bot_pix  = bot_q;
  assign dsp_shift_en = shift_en_q;
  assign dsp_mode     = mode_q;
  assign out_valid    = out_valid_q;
  assign out_pix      = out_pix_q;
  assign out_last     = out_last_q;

endmodule

`default_nettype wire

// File: tb/tb_dsp_frame_ctrl.sv
// ============================================================================
// tb_dsp_frame_ctrl: scoreboard bench for dsp_frame_ctrl on a 4x4 frame.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_dsp_frame_ctrl;

  localparam int W = 4;
  localparam int H = 4;
  localparam int L = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  mode_in = 2'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_pix = '0;
  logic [31:0] dsp_top_pix, dsp_mid_pix, dsp_bot_pix;
  logic        dsp_shift_en;
  logic [1:0]  dsp_mode;
  logic [31:0] dsp_pixel_in;
  logic        out_valid, out_last, busy, done;
  logic [31:0] out_pix;

  dsp_frame_ctrl #(.IMG_W(W), .IMG_H(H), .CONV_LAT(L)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode_in(mode_in),
    .in_valid(in_valid), .in_ready(in_ready), .in_pix(in_pix),
    .dsp_top_pix(dsp_top_pix), .dsp_mid_pix(dsp_mid_pix), .dsp_bot_pix(dsp_bot_pix),
    .dsp_shift_en(dsp_shift_en), .dsp_mode(dsp_mode), .dsp_pixel_in(dsp_pixel_in),
    .out_valid(out_valid), .out_pix(out_pix), .out_last(out_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in dsp: one-cycle latency, returns the centre pixel of the window
  logic [31:0] w0_mid;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dsp_pixel_in <= '0;
      w0_mid       <= '0;
    end else if (dsp_shift_en) begin
      dsp_pixel_in <= w0_mid;
      w0_mid       <= dsp_mid_pix;
    end
  end

  typedef struct packed {
    logic [31:0] cyc;
    logic        last;
    logic [31:0] pix;
  } out_t;

  typedef struct packed {
    logic        chk;
    logic [31:0] top;
    logic [31:0] mid;
    logic [31:0] bot;
  } win_t;

  out_t out_q[$];
  win_t win_q[$];

  logic [31:0] img [H][W];
  // Interior centres (1,1),(1,2),(2,1),(2,2) of the row*16+col pattern
  localparam logic [31:0] EXP_PAT [4] = '{32'h00111111, 32'h00121212, 32'h00212121, 32'h00222222};

  int n_checks = 0;
  int n_fail   = 0;
  int last_acc = 0;
  int n_lit    = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chkb(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboards whenever the DUT presents a window or a result
  always @(negedge clk) begin
    out_t e;
    win_t w;
    if (rst_n) begin
      if (out_valid) begin
        if (out_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL spurious_out: got out_pix %h expected no out_valid (cycle %0d)", out_pix, cyc);
        end else begin
          e = out_q.pop_front();
          chk("out_pix", out_pix, e.pix);
          chkb("out_last", out_last, e.last);
          chk("out_cycle", cyc, e.cyc);
        end
      end
      if (dsp_shift_en) begin
        if (win_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL spurious_shift: got shift_en 1 expected 0 without accept (cycle %0d)", cyc);
        end else begin
          w = win_q.pop_front();
          if (w.chk) begin
            chk("win_top", dsp_top_pix, w.top);
            chk("win_mid", dsp_mid_pix, w.mid);
            chk("win_bot", dsp_bot_pix, w.bot);
          end
        end
      end
    end
  end

  task automatic fill(input bit pat);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = pat ? {8'h00, {3{8'(r*16 + c)}}} : $urandom;
  endtask

  task automatic start_frame(input logic [1:0] m);
    @(negedge clk);
    mode_in = m;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chkb("busy_after_start", busy, 1'b1);
    chk("mode_latched", {30'd0, dsp_mode}, {30'd0, m});
  endtask

  // gaps: 0 continuous, 1 toggle, 2 random. Start is pulsed with accept index poke_k.
  task automatic run_frame(input int npix, input int gaps, input bit pat,
                           input int poke_k, input logic [1:0] poke_mode);
    int   k = 0;
    int   budget = 0;
    int   r, c;
    bit   tog = 1'b1;
    logic v;
    out_t e;
    win_t w;
    if (pat) n_lit = 0;
    while (k < npix && budget < 2000) begin
      @(negedge clk);
      budget++;
      r = k / W;
      c = k % W;
      case (gaps)
        0:       v = 1'b1;
        1:       begin v = tog; tog = ~tog; end
        default: v = 1'($urandom_range(0, 1));
      endcase
      in_valid = v;
      in_pix   = img[r][c];
      start    = 1'b0;
      if (v && in_ready) begin
        if (k == poke_k) begin
          start   = 1'b1;
          mode_in = poke_mode;
        end
        w.chk = (r >= 2);
        w.top = (r >= 2) ? img[r-2][c] : '0;
        w.mid = (r >= 2) ? img[r-1][c] : '0;
        w.bot = img[r][c];
        win_q.push_back(w);
        if (r >= 2 && c >= 2) begin
          e.cyc  = cyc + 2 + L;
          e.last = (r == H-1) && (c == W-1);
          e.pix  = pat ? EXP_PAT[n_lit] : img[r-1][c-1];
          if (pat) n_lit++;
          out_q.push_back(e);
        end
        last_acc = cyc;
        k++;
      end
    end
    if (k < npix) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout: got %0d accepts expected %0d", k, npix);
    end
    @(negedge clk);
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic end_frame(input bit chain, input logic [1:0] nmode);
    int b = 0;
    while (!done && b < 50) begin
      @(negedge clk);
      b++;
    end
    chkb("done_seen", done, 1'b1);
    chk("done_cycle", cyc, last_acc + 4);
    chkb("busy_at_done", busy, 1'b0);
    chk("out_q_drained", out_q.size(), 0);
    chk("win_q_drained", win_q.size(), 0);
    if (chain) begin
      mode_in = nmode;
      start   = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chkb("done_width", done, 1'b0);
      chkb("busy_back_to_back", busy, 1'b1);
    end else begin
      @(negedge clk);
      chkb("done_width", done, 1'b0);
      chkb("busy_idle", busy, 1'b0);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chkb("rst_in_ready", in_ready, 1'b0);
    chkb("rst_busy", busy, 1'b0);
    chkb("rst_done", done, 1'b0);
    chkb("rst_out_valid", out_valid, 1'b0);
    chkb("rst_out_last", out_last, 1'b0);
    chkb("rst_shift_en", dsp_shift_en, 1'b0);
    chk("rst_mode", {30'd0, dsp_mode}, 32'd0);
    chk("rst_top", dsp_top_pix, 32'd0);
    chk("rst_mid", dsp_mid_pix, 32'd0);
    chk("rst_bot", dsp_bot_pix, 32'd0);
    chk("rst_out_pix", out_pix, 32'd0);
    rst_n = 1'b1;

    // Continuous pattern frame, then the same frame back-to-back with toggled valid;
    // the second frame also pulses start together with its final accept.
    fill(1'b1);
    start_frame(2'd0);
    run_frame(W*H, 0, 1'b1, -1, 2'd0);
    end_frame(1'b1, 2'd0);
    run_frame(W*H, 1, 1'b1, W*H-1, 2'd0);
    end_frame(1'b0, 2'd0);

    // Random data, random gaps, mode change plus start mid-frame
    fill(1'b0);
    start_frame(2'd0);
    run_frame(W*H, 2, 1'b0, 6, 2'd3);
    chk("mode_hold", {30'd0, dsp_mode}, 32'd0);
    end_frame(1'b0, 2'd0);

    // Partial frame interrupted by reset
    fill(1'b1);
    start_frame(2'd2);
    run_frame(7, 0, 1'b1, -1, 2'd0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chkb("midrst_in_ready", in_ready, 1'b0);
    chkb("midrst_out_valid", out_valid, 1'b0);
    chkb("midrst_busy", busy, 1'b0);
    chkb("midrst_shift_en", dsp_shift_en, 1'b0);
    chk("midrst_mode", {30'd0, dsp_mode}, 32'd0);
    out_q.delete();
    win_q.delete();
    @(negedge clk);
    rst_n = 1'b1;

    // Clean frame after reset with fresh data over stale line buffers
    fill(1'b0);
    start_frame(2'd1);
    run_frame(W*H, 2, 1'b0, -1, 2'd0);
    end_frame(1'b0, 2'd0);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
